// File: rtl/s3rb_issue_queue.sv
// s3rb_issue_queue: buffers 24-bit instructions and issues them one at a time to s3rb.
// Optional WAIT timeout/abort enabled by defining S3RB_ISSUE_TIMEOUT_EN.
module s3rb_issue_queue #(
  parameter int         DEPTH       = 4,
  parameter int         PTR_W       = 2,
  parameter logic [3:0] IDLE_OPCODE = 4'h0,
  parameter int         TIMEOUT     = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [23:0]      in_instr,
  output logic             in_ready,
  input  logic             done,
  output logic [3:0]       opcode,
  output logic [3:0]       operand1,
  output logic [15:0]      operand2,
  output logic             busy,
  output logic [PTR_W:0]   fifo_count,
  output logic [7:0]       retire_cnt,
  output logic             timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [23:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       state;

  logic push;
  logic pop;
  logic has_entry;
  logic retire;
  logic tmo;
  logic finish;

  assign in_ready  = (fifo_count < CNT_FULL);
  assign has_entry = (fifo_count != '0);
  assign push      = in_valid & in_ready;
  assign retire    = (state == S_WAIT) & done;
  assign finish    = retire | tmo;
  assign pop       = has_entry &
                     ((state == S_IDLE) |
                      ((state == S_WAIT) & finish));
  assign busy      = (state == S_ISSUE) |
                     (state == S_WAIT);

`ifdef S3RB_ISSUE_TIMEOUT_EN
  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST =
    WC_W'(TIMEOUT - 1);

  logic [WC_W-1:0] wcnt;

  assign tmo = (state == S_WAIT) & ~done &
               (wcnt == WC_LAST);

  // WAIT cycle counter, restarted while the op sits in ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
    end else if (state == S_ISSUE) begin
      wcnt <= '0;
    end else if (state == S_WAIT) begin
      wcnt <= wcnt + WC_W'(1);
    end
  end

  // sticky abort flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (tmo) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_instr;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // issue FSM: ISSUE lasts one cycle so a stale done is never taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (has_entry) begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (finish) begin
            state <= has_entry ? S_ISSUE : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // registered s3rb operands: load on pop, idle values when draining
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode   <= IDLE_OPCODE;
      operand1 <= '0;
      operand2 <= '0;
    end else if (pop) begin
      opcode   <= mem[rd_ptr][23:20];
      operand1 <= mem[rd_ptr][19:16];
      operand2 <= mem[rd_ptr][15:0];
    end else if ((state == S_WAIT) & finish) begin
      opcode   <= IDLE_OPCODE;
      operand1 <= '0;
      operand2 <= '0;
    end
  end

  // retired-instruction counter, wraps naturally at 8 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_s3rb_issue_queue.sv
// tb_s3rb_issue_queue: vector table, directed corner sequences
// and random traffic against a queue-based reference model.
module tb_s3rb_issue_queue;

  localparam int         DEPTH   = 4;
  localparam int         PTR_W   = 2;
  localparam logic [3:0] IDLE_OP = 4'h0;
  localparam int         TIMEOUT = 15;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [23:0] in_instr;
  logic        in_ready;
  logic        done;
  logic [3:0]  opcode;
  logic [3:0]  operand1;
  logic [15:0] operand2;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [7:0]  retire_cnt;
  logic        timeout_err;

  int checks;
  int failures;

  s3rb_issue_queue #(
    .DEPTH(DEPTH), .PTR_W(PTR_W),
    .IDLE_OPCODE(IDLE_OP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .done(done),
    .opcode(opcode), .operand1(operand1),
    .operand2(operand2), .busy(busy),
    .fifo_count(fifo_count),
    .retire_cnt(retire_cnt),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          r;
    bit          v;
    logic [23:0] ins;
    bit          d;
    logic [3:0]  eop;
    logic [3:0]  eo1;
    logic [15:0] eo2;
    bit          ebusy;
    int          ecnt;
    bit          erdy;
    int          eret;
  } vec_t;

  vec_t vecs[14];

  // reference model state
  logic [23:0] q[$];
  logic [23:0] cur;
  bit          inflight;
  int          age;
  int          m_ret;
  bit          m_terr;

  function automatic vec_t mk(
    bit r, bit v, logic [23:0] ins, bit d,
    logic [3:0] eop, logic [3:0] eo1,
    logic [15:0] eo2, bit eb, int ec,
    bit er, int ert);
    vec_t x;
    x.r = r; x.v = v; x.ins = ins; x.d = d;
    x.eop = eop; x.eo1 = eo1; x.eo2 = eo2;
    x.ebusy = eb; x.ecnt = ec; x.erdy = er;
    x.eret = ert;
    return x;
  endfunction

  task automatic chk(string nm,
                     logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  task automatic model_edge(bit r, bit v,
                            logic [23:0] ins,
                            bit d);
    bit acc;
    bit fin;
    if (r) begin
      q.delete();
      inflight = 0;
      age = 0;
      m_ret = 0;
      m_terr = 0;
    end else begin
      acc = v && (q.size() < DEPTH);
      fin = 0;
      if (!inflight) begin
        if (q.size() > 0) begin
          cur = q.pop_front();
          inflight = 1;
          age = 0;
        end
      end else if (age == 0) begin
        age = 1;
      end else begin
        if (d) begin
          m_ret = (m_ret + 1) % 256;
          fin = 1;
        end
`ifdef S3RB_ISSUE_TIMEOUT_EN
        else if (age == TIMEOUT) begin
          m_terr = 1;
          fin = 1;
        end
`endif
        if (fin) begin
          if (q.size() > 0) begin
            cur = q.pop_front();
            age = 0;
          end else begin
            inflight = 0;
          end
        end else begin
          age++;
        end
      end
      if (acc) q.push_back(ins);
    end
  endtask

  task automatic check_model(string nm);
    logic [3:0]  eop;
    logic [3:0]  eo1;
    logic [15:0] eo2;
    bit          bad;
    eop = inflight ? cur[23:20] : IDLE_OP;
    eo1 = inflight ? cur[19:16] : 4'h0;
    eo2 = inflight ? cur[15:0]  : 16'h0;
    bad = (opcode !== eop) ||
          (operand1 !== eo1) ||
          (operand2 !== eo2) ||
          (busy !== inflight) ||
          (fifo_count !== 3'(q.size())) ||
          (in_ready !== (q.size() < DEPTH)) ||
          (retire_cnt !== 8'(m_ret)) ||
          (timeout_err !== m_terr);
    checks++;
    if (bad) begin
      failures++;
      $display({"FAIL %s: got op=%h o1=%h o2=%h b=%b",
                " cnt=%0d rdy=%b ret=%0d te=%b",
                " expected op=%h o1=%h o2=%h b=%b",
                " cnt=%0d rdy=%b ret=%0d te=%b"},
               nm, opcode, operand1, operand2, busy,
               fifo_count, in_ready, retire_cnt,
               timeout_err, eop, eo1, eo2, inflight,
               q.size(), q.size() < DEPTH, m_ret,
               m_terr);
    end
  endtask

  task automatic step(bit r, bit v,
                      logic [23:0] ins, bit d,
                      string nm);
    rst = r;
    in_valid = v;
    in_instr = ins;
    done = d;
    @(posedge clk);
    model_edge(r, v, ins, d);
    #1;
    check_model(nm);
  endtask

  logic [23:0] w[6];
  bit          busy_ok;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    done = 1'b0;
    inflight = 0;
    age = 0;
    m_ret = 0;
    m_terr = 0;
    cur = '0;

    // reset, single op, done-in-ISSUE, back-to-back
    vecs[0]  = mk(1,0,24'h0,0,  0,0,16'h0,0,0,1,0);
    vecs[1]  = mk(1,0,24'h0,0,  0,0,16'h0,0,0,1,0);
    vecs[2]  = mk(0,1,24'h3200A5,0,
                  0,0,16'h0,0,1,1,0);
    vecs[3]  = mk(0,0,24'h0,0,  3,2,16'h00A5,1,0,1,0);
    vecs[4]  = mk(0,0,24'h0,0,  3,2,16'h00A5,1,0,1,0);
    vecs[5]  = mk(0,0,24'h0,0,  3,2,16'h00A5,1,0,1,0);
    vecs[6]  = mk(0,0,24'h0,1,  0,0,16'h0,0,0,1,1);
    vecs[7]  = mk(0,0,24'h0,0,  0,0,16'h0,0,0,1,1);
    vecs[8]  = mk(0,1,24'h511234,1,
                  0,0,16'h0,0,1,1,1);
    vecs[9]  = mk(0,1,24'h7FBEEF,1,
                  5,1,16'h1234,1,1,1,1);
    vecs[10] = mk(0,0,24'h0,1,  5,1,16'h1234,1,1,1,1);
    vecs[11] = mk(0,0,24'h0,1,  7,4'hF,16'hBEEF,1,0,1,2);
    vecs[12] = mk(0,0,24'h0,0,  7,4'hF,16'hBEEF,1,0,1,2);
    vecs[13] = mk(0,0,24'h0,1,  0,0,16'h0,0,0,1,3);

    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].r;
      in_valid = vecs[i].v;
      in_instr = vecs[i].ins;
      done = vecs[i].d;
      @(posedge clk);
      #1;
      checks++;
      if (opcode !== vecs[i].eop ||
          operand1 !== vecs[i].eo1 ||
          operand2 !== vecs[i].eo2 ||
          busy !== vecs[i].ebusy ||
          fifo_count !== 3'(vecs[i].ecnt) ||
          in_ready !== vecs[i].erdy ||
          retire_cnt !== 8'(vecs[i].eret) ||
          timeout_err !== 1'b0) begin
        failures++;
        $display({"FAIL vec%0d: got op=%h o1=%h",
                  " o2=%h b=%b cnt=%0d rdy=%b ret=%0d",
                  " te=%b expected op=%h o1=%h o2=%h",
                  " b=%b cnt=%0d rdy=%b ret=%0d te=0"},
                 i, opcode, operand1, operand2, busy,
                 fifo_count, in_ready, retire_cnt,
                 timeout_err, vecs[i].eop,
                 vecs[i].eo1, vecs[i].eo2,
                 vecs[i].ebusy, vecs[i].ecnt,
                 vecs[i].erdy, vecs[i].eret);
      end
    end

    // fill: 5 pushes with done low, 6th word blocked
    w[0] = 24'h1A0001; w[1] = 24'h2B0002;
    w[2] = 24'h3C0003; w[3] = 24'h4D0004;
    w[4] = 24'h5E0005; w[5] = 24'h6F0006;
    step(1, 0, 24'h0, 0, "fill_rst");
    step(1, 0, 24'h0, 0, "fill_rst");
    for (int k = 0; k < 5; k++)
      step(0, 1, w[k], 0, "fill_push");
    chk("fill_count", 32'(fifo_count), 32'd4);
    chk("fill_ready", 32'(in_ready), 32'd0);
    chk("fill_head_op", 32'(opcode), 32'h1);
    for (int k = 0; k < 3; k++)
      step(0, 1, w[5], 0, "fill_blocked");
    chk("fill_still4", 32'(fifo_count), 32'd4);
    for (int k = 0; k < 20; k++)
      step(0, 1, w[5], 0, "fill_hold");
`ifdef S3RB_ISSUE_TIMEOUT_EN
    chk("timeout_flag", 32'(timeout_err), 32'd1);
    chk("timeout_noret", 32'(retire_cnt), 32'd0);
`else
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_op", 32'(operand2), 32'h0001);
`endif
    for (int k = 0; k < 16; k++)
      step(0, 0, 24'h0, 1, "fill_drain");
    chk("drain_idle", 32'(busy), 32'd0);

    // back-to-back: done held high throughout
    step(1, 0, 24'h0, 0, "b2b_rst");
    busy_ok = 1;
    for (int k = 1; k <= 8; k++) begin
      step(0, k <= 3, w[k-1], 1, "b2b");
      if (k >= 2 && k <= 7 && busy !== 1'b1)
        busy_ok = 0;
      if (k == 2) chk("b2b_first", 32'(opcode), 32'h1);
      if (k == 3) chk("b2b_issue_done",
                      32'(retire_cnt), 32'd0);
      if (k == 4) chk("b2b_second", 32'(opcode), 32'h2);
      if (k == 6) chk("b2b_third", 32'(opcode), 32'h3);
    end
    chk("b2b_busy_held", 32'(busy_ok), 32'd1);
    chk("b2b_retired", 32'(retire_cnt), 32'd3);

    // reset during WAIT with two entries queued
    step(1, 0, 24'h0, 0, "mid_rst0");
    for (int k = 0; k < 3; k++)
      step(0, 1, w[k], 0, "mid_push");
    chk("mid_queued", 32'(fifo_count), 32'd2);
    step(1, 0, 24'h0, 1, "mid_rst");
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_count", 32'(fifo_count), 32'd0);
    chk("mid_retire", 32'(retire_cnt), 32'd0);
    for (int k = 0; k < 3; k++)
      step(0, 0, 24'h0, 1, "mid_after");

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 1) == 1,
           24'($urandom),
           $urandom_range(0, 9) < 3,
           "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
